// File: rtl/relu6_pkg.sv
// Shared FP16 types, constants and classification helpers for the ReLU6 family.
package relu6_pkg;

  typedef logic [15:0] fp16_t;

  localparam fp16_t      FP16_ZERO = 16'h0000;
  localparam fp16_t      FP16_SIX  = 16'h4600;
  localparam fp16_t      FP16_QNAN = 16'h7E00;
  localparam logic [4:0] FP16_EXP_MAX = 5'h1F;

  // Payload captured by the classify stage.
  typedef struct packed {
    fp16_t grad;
    logic  last;
    logic  pass;
    logic  nan;
  } s1_payload_t;

  function automatic logic fp16_is_zero(input fp16_t v);
    return (v[14:0] == 15'h0000);
  endfunction

  function automatic logic fp16_is_nan(input fp16_t v);
    return (v[14:10] == FP16_EXP_MAX) && (v[9:0] != 10'h000);
  endfunction

endpackage

// File: rtl/relu6_backward_if.sv
// Input-pair and output-gradient streams of the ReLU6 backward unit.
interface relu6_backward_if;
  import relu6_pkg::*;

  logic  in_valid;
  logic  in_ready;
  fp16_t in_x;
  fp16_t in_grad;
  logic  in_last;
  logic  out_valid;
  logic  out_ready;
  fp16_t out_grad;
  logic  out_last;

  modport slave (
    input  in_valid, in_x, in_grad, in_last, out_ready,
    output in_ready, out_valid, out_grad, out_last
  );

  modport master (
    output in_valid, in_x, in_grad, in_last, out_ready,
    input  in_ready, out_valid, out_grad, out_last
  );

endinterface

// File: rtl/fp16_relu6_mask.sv
// Combinational ReLU6 window test: pass when 0 < x < 6.0, plus a NaN flag.
module fp16_relu6_mask
  import relu6_pkg::*;
(
  input  fp16_t i_x,
  output logic  o_pass,
  output logic  o_nan
);

  // For positive x the FP16 magnitude order equals the unsigned order of x[14:0].
  always_comb begin
    o_pass = 1'b0;
    o_nan  = fp16_is_nan(i_x);
    if (i_x[15] == 1'b1) begin
      o_pass = 1'b0;
    end else if (fp16_is_zero(i_x)) begin
      o_pass = 1'b0;
    end else if (i_x[14:0] < FP16_SIX[14:0]) begin
      o_pass = 1'b1;
    end else begin
      o_pass = 1'b0;
    end
  end

endmodule

// File: rtl/relu6_backward.sv
// FP16 ReLU6 backward gate: two-stage elastic pipeline with zeroed-gradient counter.
// Optional macro RELU6_BWD_NAN_PROP_EN: NaN x forces canonical qNaN and is not counted.
module relu6_backward
  import relu6_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  relu6_backward_if.slave  bus,
  input  logic             clr_count,
  output logic [CNT_W-1:0] zeroed_count
);

`ifdef RELU6_BWD_NAN_PROP_EN
  localparam logic L_NAN_PROP = 1'b1;
`else
  localparam logic L_NAN_PROP = 1'b0;
`endif

  localparam logic [CNT_W-1:0] L_CNT_ONE = CNT_W'(1);

  logic             w_pass;
  logic             w_nan;
  logic             w_s1_advance;
  logic             w_in_ready;
  logic             w_in_fire;
  logic             w_out_fire;
  fp16_t            w_s2_grad;
  logic             w_s2_zeroed;
  logic             w_cnt_inc;

  logic             r_s1_valid;
  s1_payload_t      r_s1;
  logic             r_s2_valid;
  fp16_t            r_s2_grad;
  logic             r_s2_last;
  logic             r_s2_zeroed;
  logic [CNT_W-1:0] r_count;

  fp16_relu6_mask u_mask (
    .i_x    (bus.in_x),
    .o_pass (w_pass),
    .o_nan  (w_nan)
  );

  // in_ready follows out_ready combinationally so a full pipe still streams.
  always_comb begin
    w_s1_advance = !r_s2_valid || bus.out_ready;
    w_in_ready   = !r_s1_valid || w_s1_advance;
    w_in_fire    = bus.in_valid && w_in_ready;
    w_out_fire   = r_s2_valid && bus.out_ready;
    w_cnt_inc    = w_out_fire && r_s2_zeroed && (r_count != {CNT_W{1'b1}});
  end

  // Gate decision, evaluated as the pair moves into the output register.
  always_comb begin
    w_s2_grad   = FP16_ZERO;
    w_s2_zeroed = 1'b1;
    if (L_NAN_PROP && r_s1.nan) begin
      w_s2_grad   = FP16_QNAN;
      w_s2_zeroed = 1'b0;
    end else if (r_s1.pass) begin
      w_s2_grad   = r_s1.grad;
      w_s2_zeroed = 1'b0;
    end else begin
      w_s2_grad   = FP16_ZERO;
      w_s2_zeroed = 1'b1;
    end
  end

  // Stage 1: classify x and capture the gradient.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1       <= '0;
    end else begin
      if (w_in_ready) begin
        r_s1_valid <= bus.in_valid;
      end
      if (w_in_fire) begin
        r_s1.grad <= bus.in_grad;
        r_s1.last <= bus.in_last;
        r_s1.pass <= w_pass;
        r_s1.nan  <= w_nan;
      end
    end
  end

  // Stage 2: registered outputs, held while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_valid  <= 1'b0;
      r_s2_grad   <= FP16_ZERO;
      r_s2_last   <= 1'b0;
      r_s2_zeroed <= 1'b0;
    end else if (w_s1_advance) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_grad   <= w_s2_grad;
        r_s2_last   <= r_s1.last;
        r_s2_zeroed <= w_s2_zeroed;
      end
    end
  end

  // Saturating zeroed-transfer counter; clear wins over increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (clr_count) begin
      r_count <= '0;
    end else if (w_cnt_inc) begin
      r_count <= r_count + L_CNT_ONE;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_s2_valid;
  assign bus.out_grad  = r_s2_grad;
  assign bus.out_last  = r_s2_last;
  assign zeroed_count  = r_count;

endmodule

// File: tb/tb_relu6_backward.sv
// Scoreboard bench for relu6_backward: random and directed pairs against a real-valued model.
module tb_relu6_backward;

  localparam int TB_CNT_W = 4;

  typedef struct {
    logic [15:0] grad;
    logic        last;
    logic        zeroed;
    int          cyc;
  } exp_t;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                clr_count = 1'b0;
  logic [TB_CNT_W-1:0] zeroed_count;

  relu6_backward_if bus ();

  relu6_backward #(.CNT_W(TB_CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .clr_count    (clr_count),
    .zeroed_count (zeroed_count)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   model_cnt = 0;
  int   last_lat = -1;
  int   ready_mode = 0;
  exp_t sbq[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Reference: decode x to a real magnitude and apply 0 < x < 6.
  function automatic exp_t ref_model(input logic [15:0] x, input logic [15:0] g, input logic last);
    exp_t r;
    int   e;
    int   f;
    real  mag;
    bit   nan;
    bit   pass;
    e = int'(x[14:10]);
    f = int'(x[9:0]);
    nan = (e == 31) && (f != 0);
    if (e == 31) mag = 1.0e9;
    else if (e == 0) mag = f / 16777216.0;
    else mag = (1024.0 + f) * (2.0 ** (e - 25));
    pass = (x[15] == 1'b0) && (mag > 0.0) && (mag < 6.0);
    r.last = last;
    r.cyc  = cyc;
`ifdef RELU6_BWD_NAN_PROP_EN
    if (nan) begin
      r.grad = 16'h7E00;
      r.zeroed = 1'b0;
      return r;
    end
`endif
    r.grad   = pass ? g : 16'h0000;
    r.zeroed = !pass;
    return r;
  endfunction

  // out_ready generator: 0 always, 1 pattern 1,0,0, 2 random, 3 stalled, 4 manual.
  int phase = 0;
  always @(posedge clk) begin
    #3;
    case (ready_mode)
      0: bus.out_ready = 1'b1;
      1: begin bus.out_ready = (phase == 0); phase = (phase + 1) % 3; end
      2: bus.out_ready = 1'($urandom_range(0, 1));
      3: bus.out_ready = 1'b0;
      default: ;
    endcase
  end

  // Monitor: pops the scoreboard on every output transfer, tracks count and stall stability.
  logic        have_hold = 1'b0;
  logic [15:0] hold_grad;
  logic        hold_last;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        sbq.delete();
        model_cnt = 0;
        have_hold = 1'b0;
      end else begin
        check("zeroed_count", int'(zeroed_count), model_cnt);
        if (have_hold) begin
          check("stall_valid", int'(bus.out_valid), 1);
          check("stall_data", int'({bus.out_grad, bus.out_last}), int'({hold_grad, hold_last}));
        end
        have_hold = bus.out_valid && !bus.out_ready;
        hold_grad = bus.out_grad;
        hold_last = bus.out_last;
        if (bus.out_valid && bus.out_ready) begin
          if (sbq.size() == 0) begin
            check("spurious_out", 1, 0);
          end else begin
            e = sbq.pop_front();
            check("out_grad", int'(bus.out_grad), int'(e.grad));
            check("out_last", int'(bus.out_last), int'(e.last));
            last_lat = cyc - e.cyc;
            if (!clr_count && e.zeroed && model_cnt < (1 << TB_CNT_W) - 1) model_cnt++;
          end
        end
        if (clr_count) model_cnt = 0;
      end
    end
  end

  // Called at posedge+2; returns at posedge+2 after the handshake.
  task automatic send(input logic [15:0] x, input logic [15:0] g, input logic last);
    bit done = 0;
    bus.in_valid = 1'b1;
    bus.in_x = x;
    bus.in_grad = g;
    bus.in_last = last;
    for (int n = 0; n < 300 && !done; n++) begin
      @(negedge clk); #1;
      if (bus.in_ready && !rst) begin
        sbq.push_back(ref_model(x, g, last));
        done = 1;
      end
      @(posedge clk); #2;
    end
    bus.in_valid = 1'b0;
    if (!done) check("send_timeout", 0, 1);
  endtask

  task automatic drain();
    bit done = 0;
    for (int n = 0; n < 400 && !done; n++) begin
      @(posedge clk); #1;
      if (sbq.size() == 0) done = 1;
    end
    if (!done) check("drain_timeout", sbq.size(), 0);
    #1;
  endtask

  function automatic logic [15:0] rand_x();
    logic [15:0] v;
    v = 16'($urandom);
    if ($urandom_range(0, 1) == 1) v[14:10] = 5'($urandom_range(0, 18));
    return v;
  endfunction

  logic [15:0] blk_x [5] = '{16'h4600, 16'h0000, 16'h8000, 16'hC000, 16'h7C00};

  initial begin
    int acc;
    bus.in_valid = 1'b0;
    bus.in_x = 16'h0000;
    bus.in_grad = 16'h0000;
    bus.in_last = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_out_grad", int'(bus.out_grad), 0);
    check("rst_out_last", int'(bus.out_last), 0);
    check("rst_count", int'(zeroed_count), 0);
    check("rst_in_ready", int'(bus.in_ready), 1);
    @(posedge clk); #2;

    send(16'h3C00, 16'hBC00, 1'b0);
    drain();
    check("latency", last_lat, 2);
    check("pass_count", int'(zeroed_count), 0);

    foreach (blk_x[i]) send(blk_x[i], 16'h4000, 1'b0);
    send(16'h0001, 16'h4000, 1'b0);
    drain();
    check("blocked_count5", int'(zeroed_count), 5);

    // Back-to-back 8 pairs under a 1,0,0 ready pattern.
    @(posedge clk); #2;
    ready_mode = 1;
    for (int i = 0; i < 8; i++) send(rand_x(), 16'($urandom), i == 7);
    drain();
    ready_mode = 0;

    // Stall: in_ready must drop after exactly two accepts, then recover full rate.
    @(posedge clk); #2;
    ready_mode = 3;
    acc = 0;
    bus.in_valid = 1'b1; bus.in_x = rand_x(); bus.in_grad = 16'($urandom); bus.in_last = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); #1;
      if (bus.in_ready) begin
        sbq.push_back(ref_model(bus.in_x, bus.in_grad, bus.in_last));
        acc++;
        @(posedge clk); #2;
        bus.in_x = rand_x(); bus.in_grad = 16'($urandom);
      end else begin
        @(posedge clk); #2;
      end
    end
    check("stall_accepts", acc, 2);
    check("stall_in_ready", int'(bus.in_ready), 0);
    ready_mode = 0;
    acc = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); #1;
      if (bus.in_ready) begin
        sbq.push_back(ref_model(bus.in_x, bus.in_grad, bus.in_last));
        acc++;
        @(posedge clk); #2;
        bus.in_x = rand_x(); bus.in_grad = 16'($urandom);
      end else begin
        @(posedge clk); #2;
      end
    end
    bus.in_valid = 1'b0;
    check("full_rate_accepts", acc, 6);
    drain();

    // Clear coinciding with a blocked transfer.
    @(posedge clk); #2;
    ready_mode = 4;
    bus.out_ready = 1'b0;
    send(16'hC000, 16'h1234, 1'b0);
    send(16'h3C00, 16'h1234, 1'b0);
    for (int n = 0; n < 20 && !bus.out_valid; n++) begin @(posedge clk); #2; end
    check("clr_setup_count_nz", int'(zeroed_count != 0), 1);
    bus.out_ready = 1'b1;
    clr_count = 1'b1;
    @(posedge clk); #1;
    check("clr_priority", int'(zeroed_count), 0);
    #1 clr_count = 1'b0;
    ready_mode = 0;
    drain();

    for (int i = 0; i < 20; i++) send(16'h8000 | 16'($urandom_range(0, 32767)), 16'h3C00, 1'b0);
    drain();
    check("saturate", int'(zeroed_count), 15);

    @(posedge clk); #2;
    clr_count = 1'b1;
    @(posedge clk); #2;
    clr_count = 1'b0;
    send(16'h7E01, 16'h3C00, 1'b1);
    drain();
`ifdef RELU6_BWD_NAN_PROP_EN
    check("nan_count", int'(zeroed_count), 0);
`else
    check("nan_count", int'(zeroed_count), 1);
`endif

    // Randomized mix under random backpressure.
    @(posedge clk); #2;
    ready_mode = 2;
    for (int i = 0; i < 200; i++) send(rand_x(), 16'($urandom), 1'($urandom_range(0, 1)));
    drain();

    // Reset while pairs are in flight.
    @(posedge clk); #2;
    ready_mode = 3;
    send(16'hC000, 16'h1111, 1'b0);
    send(16'h3C00, 16'h2222, 1'b0);
    @(posedge clk); #2;
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    check("midrst_out_valid", int'(bus.out_valid), 0);
    check("midrst_count", int'(zeroed_count), 0);
    check("midrst_in_ready", int'(bus.in_ready), 1);
    ready_mode = 0;
    repeat (4) @(posedge clk);
    #2;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
